// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the RAM access sequencer: FSM states, store sizes, grant ids.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/store_lane_merge.sv
// Replaces the addressed byte/halfword lanes of a RAM word with store data
// (little-endian lane order) and flags accesses that break natural alignment.
module store_lane_merge
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged,
    output logic        misalign
);

    // Lane replacement and alignment check by access size
    always_comb begin
        merged   = old_word;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                misalign = addr_lo[0];
                if (addr_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: begin
                misalign = (addr_lo != 2'b00);
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates the single-port data RAM between instruction fetch and the data
// port, and performs sub-word stores as read-modify-write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RR_ARB = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic [31:0]       hold_q, hold_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [1:0]        op_size_q, op_size_d;
    logic [31:0]       op_wdata_q, op_wdata_d;

    logic              gnt_i, gnt_d;
    logic              ram_we_c;
    logic [ADDR_W-1:0] addr_mux;
    logic [31:0]       wdata_c;

    logic [31:0]       chk_wdata;
    logic [1:0]        chk_size;
    logic [1:0]        chk_lo;
    logic [31:0]       merged;
    logic              misalign;

    // One merge unit serves both the IDLE alignment check (live request)
    // and the MERGE write (latched request).
    assign chk_wdata = (state_q == MERGE) ? op_wdata_q     : d_wdata;
    assign chk_size  = (state_q == MERGE) ? op_size_q      : d_size;
    assign chk_lo    = (state_q == MERGE) ? op_addr_q[1:0] : d_addr[1:0];

    store_lane_merge u_merge (
        .old_word (hold_q),
        .wdata    (chk_wdata),
        .size     (chk_size),
        .addr_lo  (chk_lo),
        .merged   (merged),
        .misalign (misalign)
    );

    // Arbitration, next-state and RAM control decode
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        hold_d       = hold_q;
        err_d        = err_q;
        op_addr_d    = op_addr_q;
        op_size_d    = op_size_q;
        op_wdata_d   = op_wdata_q;
        gnt_i        = 1'b0;
        gnt_d        = 1'b0;
        ram_we_c     = 1'b0;
        addr_mux     = op_addr_q;
        wdata_c      = d_wdata;

        case (state_q)
            IDLE: begin
                gnt_d = d_req && (!i_req || (RR_ARB == 0) || (last_grant_q == GNT_I));
                gnt_i = i_req && !gnt_d;
                if (gnt_i) begin
                    last_grant_d = GNT_I;
                    addr_mux     = i_addr;
                    i_rdata_d    = ram_rdata;
                    err_d        = 1'b0;
                    state_d      = RESP;
                end else if (gnt_d) begin
                    last_grant_d = GNT_D;
                    addr_mux     = d_addr;
                    op_addr_d    = d_addr;
                    op_size_d    = d_size;
                    op_wdata_d   = d_wdata;
                    err_d        = misalign;
                    state_d      = RESP;
                    if (!misalign) begin
                        if (!d_we) begin
                            d_rdata_d = ram_rdata;
                        end else if ((d_size == SZ_BYTE) || (d_size == SZ_HALF)) begin
                            hold_d  = ram_rdata;
                            state_d = MERGE;
                        end else begin
                            ram_we_c = 1'b1;
                            wdata_c  = d_wdata;
                        end
                    end
                end
            end
            MERGE: begin
                ram_we_c = 1'b1;
                addr_mux = op_addr_q;
                wdata_c  = merged;
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write enable is also gated by rst so an in-flight store is dropped at once
    assign ram_we    = ram_we_c && !rst;
    assign ram_addr  = addr_mux & WORD_MASK;
    assign ram_wdata = wdata_c;

    assign i_ack   = (state_q == RESP) && (last_grant_q == GNT_I);
    assign d_ack   = (state_q == RESP) && (last_grant_q == GNT_D);
    assign d_err   = d_ack && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            hold_q       <= '0;
            err_q        <= 1'b0;
            op_addr_q    <= '0;
            op_size_q    <= '0;
            op_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
            op_addr_q    <= op_addr_d;
            op_size_q    <= op_size_d;
            op_wdata_q   <= op_wdata_d;
        end
    end

endmodule
